// File: rtl/cache_line_bus_engine_pkg.sv
// cache_line_bus_engine_pkg
//   Shared geometry for the n-way cache and its bus engine: word and line
//   widths, derived byte offsets and word-index width, and the line/word
//   types, so both sides agree on one definition.
package cache_line_bus_engine_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int LINE_WIDTH       = 256;
    localparam int DATA_PER_LINE    = LINE_WIDTH / DATA_WIDTH;
    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int DATA_BYTE_OFFSET = $clog2(DATA_WIDTH / 8);
    localparam int LINE_INDEX_WIDTH = $clog2(DATA_PER_LINE);

    typedef logic [DATA_WIDTH-1:0]                 word_t;
    // Word 0 of a line sits in bits [DATA_WIDTH-1:0].
    typedef word_t [DATA_PER_LINE-1:0]             line_t;
    typedef logic [LINE_INDEX_WIDTH-1:0]           offset_t;

endpackage

// File: rtl/cache_line_bus_engine_if.sv
// cache_line_bus_engine_if
//   Groups the cache-side line request/response signals and the word-wide
//   memory bus signals of the line bus engine.
//   Modports:
//     slave  - the engine: accepts line requests, drives the memory bus
//     master - the environment: the cache issuing requests and the memory
//              answering word transactions
interface cache_line_bus_engine_if;
    import cache_line_bus_engine_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    word_t                   req_addr;
    line_t                   req_wline;
    logic                    resp_valid;
    line_t                   resp_rline;
    logic                    mem_en;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    word_t                   mem_addr;
    word_t                   mem_wdata;
    logic                    mem_ack;
    word_t                   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wline, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rline,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wline, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rline,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_line_bus_engine.sv
// cache_line_bus_engine
//   Bus-side partner of the n-way cache. A line refill (read) or write-back
//   (write) request is broken into DATA_PER_LINE single-word transactions,
//   issued in order 0..DATA_PER_LINE-1, and completion is reported to the
//   cache with a one-cycle resp_valid carrying the refilled line.
//   Ports:
//     clk  - clock
//     rst  - asynchronous reset, active low (0 = reset)
//     bus  - slave modport: req_*/resp_* toward the cache, mem_* toward
//            the SRAM/peripheral bus
module cache_line_bus_engine
    import cache_line_bus_engine_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    cache_line_bus_engine_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam offset_t LAST_IDX  = offset_t'(DATA_PER_LINE - 1);
    localparam word_t   LINE_MASK = ~word_t'(LINE_WIDTH / 8 - 1);

    logic [1:0] state;
    offset_t    idx;
    word_t      base;
    line_t      wline;
    line_t      line_buf;
    logic       busy;

    assign busy = (state == READ) || (state == WRITE);

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_rline = line_buf;

    // The word index is OR-ed into the line-aligned base, so the address
    // never carries out of the line into the tag bits.
    assign bus.mem_en    = busy;
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_be    = busy ? '1 : '0;
    assign bus.mem_addr  = busy ? (base | (word_t'(idx) << DATA_BYTE_OFFSET)) : '0;
    assign bus.mem_wdata = (state == WRITE) ? wline[idx] : '0;

    // Request latch, word sequencing and refill buffering. The line buffer
    // is only written by read acks, so a write-back leaves the previously
    // refilled line on resp_rline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            base     <= '0;
            wline    <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base  <= bus.req_addr & LINE_MASK;
                        wline <= bus.req_wline;
                        idx   <= '0;
                        state <= bus.req_we ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    if (bus.mem_ack) begin
                        if (state == READ) begin
                            line_buf[idx] <= bus.mem_rdata;
                        end
                        idx <= idx + offset_t'(1);
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_bus_engine.sv
// tb_cache_line_bus_engine
//   Scoreboard bench for cache_line_bus_engine. Each request pushes its
//   expected word transactions and line response into queues; monitors pop
//   and compare them as the engine completes words and pulses resp_valid.
//   The memory model returns the word address as read data.
module tb_cache_line_bus_engine;
    import cache_line_bus_engine_pkg::*;

    typedef struct {
        logic  we;
        word_t addr;
        word_t data;
    } word_exp_t;

    typedef struct {
        logic  is_read;
        line_t line;
        int    latency;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cache_line_bus_engine_if bus();

    cache_line_bus_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_addr;

    word_exp_t word_q[$];
    resp_exp_t resp_q[$];
    line_t     model_rline;
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    int        accept_cyc = 0;
    int        resp_cyc = 0;
    int        ack_mode = 0;
    int        stall_cnt = 0;
    logic      in_stall = 1'b0;
    word_t     stall_addr = '0;

    task automatic checkOutput(input string name, input logic [LINE_WIDTH-1:0] actual,
                               input logic [LINE_WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic failNote(input string name, input string what);
        total++;
        bad++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Memory acknowledge: tied high (mode 0) or three wait cycles per word.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) begin
                bus.mem_ack = 1'b1;
            end else if (!bus.mem_en) begin
                bus.mem_ack = 1'b0;
                stall_cnt   = 0;
            end else if (stall_cnt == 3) begin
                bus.mem_ack = 1'b1;
                stall_cnt   = 0;
            end else begin
                bus.mem_ack = 1'b0;
                stall_cnt++;
            end
        end
    end

    // Cycle counter and request-acceptance timestamp, sampled at the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst && bus.req_valid && bus.req_ready) begin
                accept_cyc = cyc;
            end
            cyc++;
        end
    end

    // Monitor: checks stall stability, completed words and line responses.
    initial begin
        word_exp_t w;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_stall = 1'b0;
            end else begin
                if (in_stall) begin
                    checkOutput("stall_mem_en", bus.mem_en, 1'b1);
                    checkOutput("stall_mem_addr", bus.mem_addr, stall_addr);
                end
                if (bus.mem_en && bus.mem_ack) begin
                    if (word_q.size() == 0) begin
                        failNote("unexpected_word", $sformatf("got addr %h, required no transaction", bus.mem_addr));
                    end else begin
                        w = word_q.pop_front();
                        checkOutput("word_we", bus.mem_we, w.we);
                        checkOutput("word_addr", bus.mem_addr, w.addr);
                        checkOutput("word_be", bus.mem_be, 4'hF);
                        if (w.we) begin
                            checkOutput("word_wdata", bus.mem_wdata, w.data);
                        end
                    end
                end
                in_stall   = bus.mem_en && !bus.mem_ack;
                stall_addr = bus.mem_addr;
                if (bus.resp_valid) begin
                    resp_cyc = cyc;
                    if (resp_q.size() == 0) begin
                        failNote("unexpected_resp", "got resp_valid=1, required 0");
                    end else begin
                        r = resp_q.pop_front();
                        checkOutput("resp_latency", cyc - accept_cyc, r.latency);
                        checkOutput(r.is_read ? "resp_rline_read" : "resp_rline_write",
                                    bus.resp_rline, r.line);
                    end
                end
            end
        end
    end

    // Queues the expected word transactions and response, then presents the
    // request and holds it until the engine takes it.
    task automatic applyStimulus(input logic we, input word_t addr, input line_t wl,
                                 input int latency);
        word_t     b;
        line_t     exp_line;
        word_exp_t w;
        resp_exp_t r;
        int        waited;
        b = addr & 32'hFFFF_FFE0;
        exp_line = '0;
        for (int k = 0; k < DATA_PER_LINE; k++) begin
            w.we   = we;
            w.addr = b + 32'(4 * k);
            w.data = we ? wl[k] : '0;
            word_q.push_back(w);
            exp_line[k] = b + 32'(4 * k);
        end
        if (!we) begin
            model_rline = exp_line;
        end
        r.is_read = !we;
        r.line    = model_rline;
        r.latency = latency;
        resp_q.push_back(r);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wline = wl;
        bus.req_valid = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) begin
            failNote("req_accept_timeout", "got req_ready=0 for 400 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while ((word_q.size() != 0 || resp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d words %0d resps pending, required 0",
                     word_q.size(), resp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        line_t wl;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wline = '0;
        model_rline   = '0;
        ack_mode      = 0;
        rst           = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", bus.req_ready, 1'b1);
        checkOutput("reset_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("reset_mem_en", bus.mem_en, 1'b0);
        checkOutput("reset_mem_we", bus.mem_we, 1'b0);
        checkOutput("reset_mem_be", bus.mem_be, 4'h0);
        checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("reset_resp_rline", bus.resp_rline, '0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] spurious mem_ack while idle");
        repeat (6) @(negedge clk);
        checkOutput("idle_ack_req_ready", bus.req_ready, 1'b1);
        checkOutput("idle_ack_mem_en", bus.mem_en, 1'b0);
        checkOutput("idle_ack_resp_valid", bus.resp_valid, 1'b0);

        $display("[TB] refill 0x80000014, ack tied high");
        applyStimulus(1'b0, 32'h8000_0014, '0, 9);
        waitDone();

        $display("[TB] write-back 0x00001040");
        for (int k = 0; k < DATA_PER_LINE; k++) begin
            wl[k] = 32'h0000_00A0 + 32'(k);
        end
        applyStimulus(1'b1, 32'h0000_1040, wl, 9);
        waitDone();

        $display("[TB] refill with three stall cycles per word");
        ack_mode = 1;
        applyStimulus(1'b0, 32'h0000_2004, '0, 33);
        waitDone();
        ack_mode = 0;
        @(negedge clk);

        $display("[TB] back-to-back refills");
        applyStimulus(1'b0, 32'h4000_0100, '0, 9);
        applyStimulus(1'b0, 32'h4000_0208, '0, 9);
        checkOutput("b2b_accept_gap", accept_cyc - resp_cyc, 1);
        waitDone();

        $display("[TB] reset during refill");
        applyStimulus(1'b0, 32'h0000_3000, '0, 9);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_mem_addr", bus.mem_addr, 32'h0000_300C);
        checkOutput("pre_reset_words_left", word_q.size(), 5);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_mem_en", bus.mem_en, 1'b0);
        checkOutput("mid_reset_req_ready", bus.req_ready, 1'b1);
        checkOutput("mid_reset_resp_valid", bus.resp_valid, 1'b0);
        word_q.delete();
        resp_q.delete();
        model_rline = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_resp_rline", bus.resp_rline, '0);

        $display("[TB] write-back after reset keeps cleared line");
        for (int k = 0; k < DATA_PER_LINE; k++) begin
            wl[k] = 32'h5A00_0000 + 32'(k);
        end
        applyStimulus(1'b1, 32'h0000_5010, wl, 9);
        waitDone();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by 100000 time units, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
